// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite scanline renderer.
// The SPRITE_MIRROR_EN build uses mirror_row to reverse a fetched bitmap row.
package sprite_pkg;
    localparam int SPR_W     = 8;
    localparam int SPR_H_DEF = 8;
    localparam int ROW_BITS  = $clog2(SPR_H_DEF);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_ADDR  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_LOAD  = 3'd4
    } fetch_state_e;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic [3:0] code;
        logic       flip;
    } slot_attr_t;

    function automatic logic [SPR_W-1:0] mirror_row(input logic [SPR_W-1:0] row);
        for (int i = 0; i < SPR_W; i++) begin
            mirror_row[i] = row[SPR_W-1-i];
        end
    endfunction
endpackage

// File: rtl/sprite_shifter.sv
// One sprite slot: pending row buffer filled during blank, live copy taken at hpos 0,
// X comparator and an 8-pixel MSB-first run.
module sprite_shifter
    import sprite_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [8:0]       hpos,
    input  logic             display_on,
    input  logic             load_en,
    input  logic             disarm_en,
    input  logic [7:0]       load_x,
    input  logic [SPR_W-1:0] load_row,
    output logic             pix_bit
);
    logic [SPR_W-1:0] pend_row_q, pend_row_d, live_row_q, live_row_d, cur_row_s;
    logic [7:0]       pend_x_q, pend_x_d, live_x_q, live_x_d, cur_x_s;
    logic             pend_arm_q, pend_arm_d, live_arm_q, live_arm_d, cur_arm_s;
    logic [SPR_W-2:0] shift_q, shift_d;
    logic [2:0]       run_q, run_d;
    logic             line_start_s, start_s;

    // Buffer handoff, run start detection and shifting.
    always_comb begin
        line_start_s = (hpos == 9'd0);
        // At hpos 0 the live copy is not yet updated, so compare against pending directly.
        cur_row_s    = line_start_s ? pend_row_q : live_row_q;
        cur_x_s      = line_start_s ? pend_x_q   : live_x_q;
        cur_arm_s    = line_start_s ? pend_arm_q : live_arm_q;
        start_s      = display_on && cur_arm_s && (run_q == 3'd0) && (hpos[7:0] == cur_x_s);
        live_row_d   = cur_row_s;
        live_x_d     = cur_x_s;
        live_arm_d   = cur_arm_s;
        pend_row_d   = pend_row_q;
        pend_x_d     = pend_x_q;
        pend_arm_d   = pend_arm_q;
        if (load_en) begin
            pend_row_d = load_row;
            pend_x_d   = load_x;
            pend_arm_d = 1'b1;
        end else if (disarm_en) begin
            pend_arm_d = 1'b0;
        end else begin
            pend_arm_d = pend_arm_q;
        end
        shift_d = shift_q;
        run_d   = run_q;
        pix_bit = 1'b0;
        if (!display_on) begin
            run_d = 3'd0;
        end else if (run_q != 3'd0) begin
            pix_bit = shift_q[SPR_W-2];
            shift_d = {shift_q[SPR_W-3:0], 1'b0};
            run_d   = run_q - 3'd1;
        end else if (start_s) begin
            pix_bit = cur_row_s[SPR_W-1];
            shift_d = cur_row_s[SPR_W-2:0];
            run_d   = 3'(SPR_W - 1);
        end else begin
            pix_bit = 1'b0;
        end
    end

    // Slot state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_row_q <= '0;
            pend_x_q   <= 8'd0;
            pend_arm_q <= 1'b0;
            live_row_q <= '0;
            live_x_q   <= 8'd0;
            live_arm_q <= 1'b0;
            shift_q    <= '0;
            run_q      <= 3'd0;
        end else begin
            pend_row_q <= pend_row_d;
            pend_x_q   <= pend_x_d;
            pend_arm_q <= pend_arm_d;
            live_row_q <= live_row_d;
            live_x_q   <= live_x_d;
            live_arm_q <= live_arm_d;
            shift_q    <= shift_d;
            run_q      <= run_d;
        end
    end
endmodule

// File: rtl/sprite_scanline_renderer.sv
// Sprite scanline renderer: blank-time ROM fetch FSM, per-slot shifters, priority and collision.
// Define SPRITE_MIRROR_EN to store attr_flip and mirror flipped slots horizontally.
module sprite_scanline_renderer
    import sprite_pkg::*;
#(
    parameter int NUM_SPRITES = 4,
    parameter int SPR_H       = 8,
    parameter int H_DISPLAY   = 256,
    parameter int V_MAX       = 261
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [8:0]                     hpos,
    input  logic [8:0]                     vpos,
    input  logic                           display_on,
    input  logic                           attr_we,
    input  logic [$clog2(NUM_SPRITES)-1:0] attr_idx,
    input  logic [7:0]                     attr_x,
    input  logic [7:0]                     attr_y,
    input  logic [3:0]                     attr_code,
    input  logic                           attr_flip,
    output logic [7+$clog2(SPR_H)-1:0]     rom_addr,
    input  logic [7:0]                     rom_data,
    output logic                           pixel_on,
    output logic [$clog2(NUM_SPRITES)-1:0] pixel_id,
    output logic                           collision,
    input  logic                           collision_clr
);
    localparam int IDX_W = $clog2(NUM_SPRITES);
    localparam int RB    = $clog2(SPR_H);
    localparam int AW    = 7 + RB;

    slot_attr_t       attr_q [NUM_SPRITES];
    slot_attr_t       attr_d [NUM_SPRITES];
    slot_attr_t       cur_attr_s;
    fetch_state_e     state_q, state_d;
    logic [IDX_W-1:0] slot_q, slot_d, pixel_id_q, pixel_id_d;
    logic [AW-1:0]    rom_addr_q, rom_addr_d;
    logic [7:0]       fetch_x_q, fetch_x_d, load_row_s;
    logic [8:0]       tline_s, row_s;
    logic             in_range_s, last_slot_s, load_s, disarm_s, multi_s;
    logic             pixel_on_q, pixel_on_d, collision_q, collision_d;
    logic [NUM_SPRITES-1:0] bits_s;

`ifdef SPRITE_MIRROR_EN
    logic fetch_flip_q, fetch_flip_d;
`else
    logic flip_unused_s;
    assign flip_unused_s = attr_flip;
`endif

    // Attribute register file write port.
    always_comb begin
        for (int i = 0; i < NUM_SPRITES; i++) begin
            attr_d[i] = attr_q[i];
        end
        if (attr_we) begin
            attr_d[attr_idx].x    = attr_x;
            attr_d[attr_idx].y    = attr_y;
            attr_d[attr_idx].code = attr_code;
`ifdef SPRITE_MIRROR_EN
            attr_d[attr_idx].flip = attr_flip;
`else
            attr_d[attr_idx].flip = 1'b0;
`endif
        end else begin
            attr_d[0] = attr_q[0];
        end
    end

    // Range check of the current slot against the line being prepared.
    always_comb begin
        tline_s     = (vpos == 9'(V_MAX)) ? 9'd0 : vpos + 9'd1;
        cur_attr_s  = attr_q[slot_q];
        row_s       = tline_s - {1'b0, cur_attr_s.y};
        in_range_s  = (row_s < 9'(SPR_H));
        last_slot_s = (slot_q == IDX_W'(NUM_SPRITES - 1));
    end

    // Fetch FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = (hpos == 9'(H_DISPLAY)) ? ST_CHECK : ST_IDLE;
            ST_CHECK: state_d = in_range_s ? ST_ADDR : (last_slot_s ? ST_IDLE : ST_CHECK);
            ST_ADDR:  state_d = ST_WAIT;
            ST_WAIT:  state_d = ST_LOAD;
            ST_LOAD:  state_d = last_slot_s ? ST_IDLE : ST_CHECK;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Fetch FSM outputs: slot sequencing, ROM address and per-slot strobes.
    always_comb begin
        slot_d     = slot_q;
        rom_addr_d = rom_addr_q;
        fetch_x_d  = fetch_x_q;
`ifdef SPRITE_MIRROR_EN
        fetch_flip_d = fetch_flip_q;
`endif
        load_s     = 1'b0;
        disarm_s   = 1'b0;
        case (state_q)
            ST_IDLE: slot_d = {IDX_W{1'b0}};
            ST_CHECK: begin
                if (in_range_s) begin
                    rom_addr_d = AW'({cur_attr_s.code, row_s[RB-1:0]});
                    fetch_x_d  = cur_attr_s.x;
`ifdef SPRITE_MIRROR_EN
                    fetch_flip_d = cur_attr_s.flip;
`endif
                end else begin
                    disarm_s = 1'b1;
                    slot_d   = last_slot_s ? {IDX_W{1'b0}} : slot_q + IDX_W'(1);
                end
            end
            ST_ADDR, ST_WAIT: slot_d = slot_q;
            ST_LOAD: begin
                load_s = 1'b1;
                slot_d = last_slot_s ? {IDX_W{1'b0}} : slot_q + IDX_W'(1);
            end
            default: slot_d = {IDX_W{1'b0}};
        endcase
    end

`ifdef SPRITE_MIRROR_EN
    assign load_row_s = fetch_flip_q ? mirror_row(rom_data) : rom_data;
`else
    assign load_row_s = rom_data;
`endif

    for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_slot
        sprite_shifter u_shifter (
            .clk        (clk),
            .reset      (reset),
            .hpos       (hpos),
            .display_on (display_on),
            .load_en    (load_s && (slot_q == IDX_W'(g))),
            .disarm_en  (disarm_s && (slot_q == IDX_W'(g))),
            .load_x     (fetch_x_q),
            .load_row   (load_row_s),
            .pix_bit    (bits_s[g])
        );
    end

    // Lowest-index priority and overlap detection; a new overlap beats a clear.
    always_comb begin
        pixel_on_d = 1'b0;
        pixel_id_d = {IDX_W{1'b0}};
        multi_s    = 1'b0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            pixel_id_d = bits_s[i] ? IDX_W'(i) : pixel_id_d;
        end
        for (int i = 0; i < NUM_SPRITES; i++) begin
            multi_s    = multi_s | (bits_s[i] & pixel_on_d);
            pixel_on_d = pixel_on_d | bits_s[i];
        end
        collision_d = multi_s ? 1'b1 : (collision_clr ? 1'b0 : collision_q);
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                attr_q[i] <= '0;
            end
            slot_q      <= {IDX_W{1'b0}};
            rom_addr_q  <= {AW{1'b0}};
            fetch_x_q   <= 8'd0;
`ifdef SPRITE_MIRROR_EN
            fetch_flip_q <= 1'b0;
`endif
            pixel_on_q  <= 1'b0;
            pixel_id_q  <= {IDX_W{1'b0}};
            collision_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                attr_q[i] <= attr_d[i];
            end
            slot_q      <= slot_d;
            rom_addr_q  <= rom_addr_d;
            fetch_x_q   <= fetch_x_d;
`ifdef SPRITE_MIRROR_EN
            fetch_flip_q <= fetch_flip_d;
`endif
            pixel_on_q  <= pixel_on_d;
            pixel_id_q  <= pixel_id_d;
            collision_q <= collision_d;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign pixel_on  = pixel_on_q;
    assign pixel_id  = pixel_id_q;
    assign collision = collision_q;
endmodule

// File: tb/tb_sprite_scanline_renderer.sv
// Directed bench for sprite_scanline_renderer; drives hpos/vpos line by line
// and models a synchronous sprite ROM.
module tb_sprite_scanline_renderer;
    localparam int H_TOTAL = 309;

    logic       clk = 1'b0;
    logic       reset;
    logic [8:0] hpos, vpos;
    logic       display_on, attr_we, attr_flip, collision_clr;
    logic [1:0] attr_idx;
    logic [7:0] attr_x, attr_y;
    logic [3:0] attr_code;
    logic [9:0] rom_addr;
    logic [7:0] rom_data;
    logic       pixel_on, collision;
    logic [1:0] pixel_id;

    logic [7:0] rom_mem [0:1023];
    logic       obs_on   [0:H_TOTAL-1];
    logic [1:0] obs_id   [0:H_TOTAL-1];
    logic       obs_col  [0:H_TOTAL-1];
    logic [9:0] obs_addr [0:H_TOTAL-1];
    logic [9:0] rst_addr;
    int checks = 0;
    int errors = 0;

    sprite_scanline_renderer dut (
        .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .display_on(display_on),
        .attr_we(attr_we), .attr_idx(attr_idx), .attr_x(attr_x), .attr_y(attr_y),
        .attr_code(attr_code), .attr_flip(attr_flip), .rom_addr(rom_addr),
        .rom_data(rom_data), .pixel_on(pixel_on), .pixel_id(pixel_id),
        .collision(collision), .collision_clr(collision_clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    task automatic write_attr(input int idx, input int x, input int y, input int code, input int flip);
        hpos       = 9'd300;
        display_on = 1'b0;
        attr_we    = 1'b1;
        attr_idx   = 2'(idx);
        attr_x     = 8'(x);
        attr_y     = 8'(y);
        attr_code  = 4'(code);
        attr_flip  = 1'(flip);
        @(posedge clk);
        #1;
        attr_we = 1'b0;
    endtask

    task automatic run_line(input int v, input int clr_h, input int rst_h);
        for (int h = 0; h < H_TOTAL; h++) begin
            hpos          = 9'(h);
            vpos          = 9'(v);
            display_on    = (h < 256);
            collision_clr = (h == clr_h);
            if (h == rst_h) begin
                reset = 1'b1;
                #1;
                rst_addr = rom_addr;
            end
            @(posedge clk);
            #1;
            reset       = 1'b0;
            obs_on[h]   = pixel_on;
            obs_id[h]   = pixel_id;
            obs_col[h]  = collision;
            obs_addr[h] = rom_addr;
        end
        collision_clr = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        if (rom_addr !== 10'd0) begin $display("FAIL reset_rom_addr got %0d want 0", rom_addr); errors++; end
        checks++;
        if (pixel_on !== 1'b0) begin $display("FAIL reset_pixel_on got %0b want 0", pixel_on); errors++; end
        checks++;
        if (pixel_id !== 2'd0) begin $display("FAIL reset_pixel_id got %0d want 0", pixel_id); errors++; end
        checks++;
        if (collision !== 1'b0) begin $display("FAIL reset_collision got %0b want 0", collision); errors++; end
        checks++;
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic [7:0] pat;
        pat = 8'hA5;
        write_attr(0, 10, 20, 3, 0);
        run_line(19, -1, -1);
        if (obs_addr[257] !== 10'd24) begin $display("FAIL basic_rom_addr got %0d want 24", obs_addr[257]); errors++; end
        checks++;
        run_line(20, -1, -1);
        for (int i = 0; i < 8; i++) begin
            if (obs_on[10+i] !== pat[7-i]) begin
                $display("FAIL basic_pixel h=%0d got %0b want %0b", 10 + i, obs_on[10+i], pat[7-i]); errors++;
            end
            checks++;
            if (obs_id[10+i] !== 2'd0) begin $display("FAIL basic_id h=%0d got %0d want 0", 10 + i, obs_id[10+i]); errors++; end
            checks++;
        end
        if (obs_on[9] !== 1'b0 || obs_on[18] !== 1'b0) begin
            $display("FAIL basic_edges got %0b/%0b want 0/0", obs_on[9], obs_on[18]); errors++;
        end
        checks++;
    endtask

    task automatic test_right_edge();
        write_attr(0, 10, 200, 3, 0);
        write_attr(1, 250, 30, 1, 0);
        run_line(29, -1, -1);
        run_line(30, -1, -1);
        for (int h = 248; h < 260; h++) begin
            if (obs_on[h] !== ((h >= 250 && h <= 255) ? 1'b1 : 1'b0)) begin
                $display("FAIL edge_pixel h=%0d got %0b", h, obs_on[h]); errors++;
            end
            checks++;
        end
        if (obs_id[252] !== 2'd1) begin $display("FAIL edge_id got %0d want 1", obs_id[252]); errors++; end
        checks++;
        run_line(31, -1, -1);
        if (obs_on[0] !== 1'b0 || obs_on[1] !== 1'b0) begin
            $display("FAIL edge_nowrap got %0b/%0b want 0/0", obs_on[0], obs_on[1]); errors++;
        end
        checks++;
    endtask

    task automatic test_collision();
        write_attr(0, 40, 50, 1, 0);
        write_attr(1, 44, 50, 1, 0);
        run_line(49, -1, -1);
        run_line(50, 100, -1);
        if (obs_col[43] !== 1'b0) begin $display("FAIL col_before got %0b want 0", obs_col[43]); errors++; end
        checks++;
        if (obs_col[44] !== 1'b1) begin $display("FAIL col_set got %0b want 1", obs_col[44]); errors++; end
        checks++;
        for (int h = 40; h < 53; h++) begin
            if (obs_on[h] !== ((h <= 51) ? 1'b1 : 1'b0)) begin $display("FAIL col_pixel h=%0d got %0b", h, obs_on[h]); errors++; end
            checks++;
            if (h <= 51 && obs_id[h] !== ((h <= 47) ? 2'd0 : 2'd1)) begin
                $display("FAIL col_id h=%0d got %0d", h, obs_id[h]); errors++;
            end
            checks++;
        end
        if (obs_col[99] !== 1'b1) begin $display("FAIL col_sticky got %0b want 1", obs_col[99]); errors++; end
        checks++;
        if (obs_col[100] !== 1'b0) begin $display("FAIL col_clear got %0b want 0", obs_col[100]); errors++; end
        checks++;
        run_line(51, 44, -1);
        if (obs_col[43] !== 1'b0) begin $display("FAIL col_cleared got %0b want 0", obs_col[43]); errors++; end
        checks++;
        if (obs_col[44] !== 1'b1) begin $display("FAIL col_set_wins got %0b want 1", obs_col[44]); errors++; end
        checks++;
    endtask

    task automatic test_vwrap();
        write_attr(0, 60, 255, 1, 0);
        write_attr(1, 80, 0, 1, 0);
        run_line(254, -1, -1);
        run_line(255, -1, -1);
        if (obs_on[59] !== 1'b0 || obs_on[60] !== 1'b1) begin
            $display("FAIL wrap_line255 got %0b%0b want 01", obs_on[59], obs_on[60]); errors++;
        end
        checks++;
        run_line(260, -1, -1);
        if (obs_addr[257] !== 10'd14) begin $display("FAIL wrap_row6_addr got %0d want 14", obs_addr[257]); errors++; end
        checks++;
        run_line(261, -1, -1);
        if (obs_on[60] !== 1'b1) begin $display("FAIL wrap_line261 got %0b want 1", obs_on[60]); errors++; end
        checks++;
        if (obs_addr[258] !== 10'd8) begin $display("FAIL wrap_y0_addr got %0d want 8", obs_addr[258]); errors++; end
        checks++;
        run_line(0, -1, -1);
        if (obs_on[60] !== 1'b0) begin $display("FAIL wrap_line0_slot0 got %0b want 0", obs_on[60]); errors++; end
        checks++;
        if (obs_on[80] !== 1'b1 || obs_on[87] !== 1'b1 || obs_on[88] !== 1'b0) begin
            $display("FAIL wrap_line0_slot1 got %0b%0b%0b want 110", obs_on[80], obs_on[87], obs_on[88]); errors++;
        end
        checks++;
        if (obs_id[80] !== 2'd1) begin $display("FAIL wrap_line0_id got %0d want 1", obs_id[80]); errors++; end
        checks++;
    endtask

    task automatic test_reset_midfetch();
        write_attr(0, 20, 101, 1, 0);
        write_attr(1, 80, 200, 1, 0);
        run_line(100, -1, 260);
        if (obs_addr[257] !== 10'd8) begin $display("FAIL rst_prefetch_addr got %0d want 8", obs_addr[257]); errors++; end
        checks++;
        if (rst_addr !== 10'd0) begin $display("FAIL rst_async_addr got %0d want 0", rst_addr); errors++; end
        checks++;
        write_attr(0, 20, 101, 1, 0);
        run_line(101, -1, -1);
        if (obs_on[20] !== 1'b0 || obs_on[24] !== 1'b0) begin
            $display("FAIL rst_dark_line got %0b/%0b want 0/0", obs_on[20], obs_on[24]); errors++;
        end
        checks++;
        run_line(102, -1, -1);
        if (obs_on[19] !== 1'b0 || obs_on[20] !== 1'b1 || obs_on[27] !== 1'b1 || obs_on[28] !== 1'b0) begin
            $display("FAIL rst_recover got %0b%0b%0b%0b want 0110", obs_on[19], obs_on[20], obs_on[27], obs_on[28]);
            errors++;
        end
        checks++;
    endtask

    task automatic test_mirror();
        logic exp_left, exp_right;
`ifdef SPRITE_MIRROR_EN
        exp_left  = 1'b0;
        exp_right = 1'b1;
`else
        exp_left  = 1'b1;
        exp_right = 1'b0;
`endif
        write_attr(0, 120, 150, 2, 1);
        run_line(149, -1, -1);
        run_line(150, -1, -1);
        if (obs_on[120] !== exp_left) begin $display("FAIL mirror_x got %0b want %0b", obs_on[120], exp_left); errors++; end
        checks++;
        if (obs_on[127] !== exp_right) begin $display("FAIL mirror_x7 got %0b want %0b", obs_on[127], exp_right); errors++; end
        checks++;
    endtask

    initial begin
        hpos = 9'd0; vpos = 9'd0; display_on = 1'b0; attr_we = 1'b0; attr_idx = 2'd0;
        attr_x = 8'd0; attr_y = 8'd0; attr_code = 4'd0; attr_flip = 1'b0; collision_clr = 1'b0;
        rst_addr = 10'd0;
        for (int i = 0; i < 1024; i++) rom_mem[i] = 8'h00;
        rom_mem[24] = 8'hA5;
        for (int i = 8; i < 16; i++) rom_mem[i] = 8'hFF;
        for (int i = 16; i < 24; i++) rom_mem[i] = 8'h80;
        test_reset();
        test_basic();
        test_right_edge();
        test_collision();
        test_vwrap();
        test_reset_midfetch();
        test_mirror();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sprite_scanline_renderer.md
Name: sprite_scanline_renderer

Overview:
- Sits directly downstream of the sync/position generator. Consumes hpos/vpos/display_on and produces per-pixel sprite coverage for the colour mux.
- During each horizontal blank, fetches one 8-pixel bitmap row per sprite from a shared sprite ROM for the next scanline.
- During the visible region, shifts those rows out at the programmed X positions.
- Flags sprite-sprite overlap through a sticky collision bit.

Parameters:
- NUM_SPRITES, 4, number of sprite slots; must be a power of two, 2..8.
- SPR_H, 8, sprite height in rows; bitmap is 8 px wide × SPR_H rows.
- H_DISPLAY, 256, first hpos of horizontal blank; the fetch sequence starts here.
- V_MAX, 261, last vpos of a frame; the line after it is 0.

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous reset, active-high
- hpos  in  9  horizontal position from the sync generator
- vpos  in  9  vertical position from the sync generator
- display_on  in  1  visible-region flag from the sync generator
- attr_we  in  1  sprite attribute write strobe
- attr_idx  in  log2(NUM_SPRITES)  sprite slot to write
- attr_x  in  8  sprite left column
- attr_y  in  8  sprite top row
- attr_code  in  4  bitmap index
- attr_flip  in  1  horizontal mirror; used only with SPRITE_MIRROR_EN
- rom_addr  out  7+log2(SPR_H)  sprite ROM address = {code, row}
- rom_data  in  8  ROM row data; valid 1 cycle after rom_addr (synchronous ROM)
- pixel_on  out  1  any sprite pixel set at this position
- pixel_id  out  log2(NUM_SPRITES)  lowest-index sprite covering the pixel
- collision  out  1  sticky overlap flag
- collision_clr  in  1  clears collision

Behaviour:
- Reset (async) clears:
  - FSM to IDLE and the slot counter to 0.
  - All attribute registers, armed flags, shift registers and run counters.
  - rom_addr, pixel_on, pixel_id and collision to 0.
- Reset mid-fetch or mid-line abandons work. Sprites stay dark until the next complete fetch.
- Attribute write: when attr_we is high, slot attr_idx updates on the next clk edge. A fetch samples a slot's attributes in that slot's CHECK cycle only.
- Target line: tline = (vpos == V_MAX) ? 0 : vpos + 1, 9-bit. Row = tline − attr_y, 9-bit unsigned. The sprite is in range iff row < SPR_H; attr_y is zero-extended.
- FSM states: IDLE, CHECK, ADDR, WAIT, LOAD.
  - IDLE→CHECK when hpos == H_DISPLAY, with slot = 0.
  - CHECK: out of range clears armed[slot] and goes to NEXT; in range goes to ADDR.
  - ADDR: drives rom_addr = {code, row[log2(SPR_H)-1:0]}.
  - WAIT: one cycle for ROM latency.
  - LOAD: latches rom_data into the pending row buffer, sets armed[slot], then NEXT.
  - NEXT: if slot == NUM_SPRITES−1 go to IDLE, else slot+1 and CHECK.
  - Worst case 4·NUM_SPRITES cycles; must finish before the next hpos 0 (≥53 blank cycles available).
- Pending buffers copy into the live shifters at hpos == 0 of each line. Fetch for line n+1 therefore never disturbs line n.
- Display:
  - When display_on and hpos[7:0] == attr_x of an armed slot, that slot starts an 8-pixel run: MSB first, one bit per clk.
  - A run is not retriggered while active.
  - A run still active when display_on falls is truncated at the right edge; no wrap to the next line.
- Outputs are registered: the pixel for hpos h appears on the cycle after hpos = h.
  - pixel_on = OR of active run bits.
  - pixel_id = lowest set index, or 0 when pixel_on is 0.
- Collision:
  - Set when ≥2 active run bits are 1 in the same cycle.
  - collision_clr clears it. If clr and a new overlap occur in the same cycle, set wins.

Optional Feature:
- Macro SPRITE_MIRROR_EN.
- Defined: attr_flip is stored per slot; a flipped slot shifts LSB first.
- Undefined: attr_flip is ignored and not stored; all slots shift MSB first.

Decomposition:
- Package sprite_pkg holds:
  - the FSM state enum;
  - the slot attribute struct {x, y, code, flip};
  - the constants SPR_W = 8 and ROW_BITS = log2(SPR_H).
- One sub-module, sprite_shifter: per-slot pending buffer, live shift register, X comparator and run counter. The top instantiates NUM_SPRITES of them plus the fetch FSM and priority/collision logic.

Test Plan:
- Slot0 x=10 y=20 code=3, ROM row 0 of code 3 = 0xA5; during blank of vpos 19 → rom_addr = {3,0}; on line 20, pixel_on over hpos 10..17 = 1,0,1,0,0,1,0,1 (one-cycle lag), pixel_id = 0.
- Slot1 x=250, row 0xFF → pixel_on for hpos 250..255 only; nothing at hpos 0 of the next line.
- Slots0/1 overlap at x=40/44, both 0xFF → collision sets at hpos 44; pixel_id = 0 on 44..47; collision_clr then clears it; clr concurrent with an overlap leaves it set.
- y=255 with V_MAX=261: rows 255..261 display rows 0..6, line 0 shows nothing; y=0 is fetched during blank of vpos 261 and shows on line 0.
- Assert reset at hpos 260 mid-fetch → rom_addr = 0 immediately, no sprite output on the next line, normal output on the line after.
- With SPRITE_MIRROR_EN, flip=1 and row 0x80 → pixel at x+7 only; without the macro → pixel at x only.
